// File: rtl/bg_scroll_controller.sv
// Horizontal background scroll sequencer: advances the fine x offset each frame and,
// on a tile-boundary crossing, shifts the tile map one column left through RAM port A.
module bg_scroll_controller #(
  parameter int TILE_COLS  = 40,
  parameter int TILE_ROWS  = 30,
  parameter int TILE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_speed,
  output logic [3:0]  x_offset,
  output logic        busy,
  output logic        frame_overrun,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        col_req,
  output logic [4:0]  col_row,
  input  logic        col_valid,
  input  logic [15:0] col_tile,
  input  logic        host_req,
  input  logic [10:0] host_addr,
  input  logic [15:0] host_data,
  output logic        host_ack
);

  typedef enum logic [2:0] {IDLE, RD, WR, NEWCOL, DONE} state_t;

  localparam logic [15:0] COLS_W         = 16'(TILE_COLS);
  localparam logic [4:0]  WIDTH_W        = 5'(TILE_WIDTH);
  localparam logic [5:0]  LAST_SHIFT_COL = 6'(TILE_COLS - 2);
  localparam logic [4:0]  LAST_ROW       = 5'(TILE_ROWS - 1);

  state_t      state;
  logic [4:0]  row;
  logic [5:0]  col;
  logic [3:0]  pend;
  logic        ack_prev;
  logic [4:0]  acc;
  logic [15:0] row_base;

  assign acc      = {1'b0, x_offset} + {1'b0, scroll_speed};
  assign row_base = 16'(row) * COLS_W;

  // Port A is decoded straight from state so each RD/WR pair costs exactly two cycles.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    host_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (host_req && !frame_tick && !ack_prev) begin
          host_ack  = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = {5'd0, host_addr};
          ram_wdata = host_data;
        end
      end
      RD: begin
        ram_addr = row_base + 16'(col) + 16'd1;
      end
      WR: begin
        ram_addr  = row_base + 16'(col);
        ram_wdata = ram_rdata;
        ram_we    = 1'b1;
      end
      NEWCOL: begin
        ram_addr = row_base + COLS_W - 16'd1;
        if (col_valid) begin
          ram_we    = 1'b1;
          ram_wdata = col_tile;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      pend          <= '0;
      ack_prev      <= 1'b0;
      x_offset      <= '0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      col_req       <= 1'b0;
      col_row       <= '0;
    end else begin
      frame_overrun <= 1'b0;
      ack_prev      <= host_ack;
      // A tick during a shift drops that frame's advance entirely.
      if (frame_tick && state != IDLE) begin
        frame_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_tick && scroll_en) begin
            if (acc < WIDTH_W) begin
              x_offset <= acc[3:0];
            end else begin
              pend  <= 4'(acc - WIDTH_W);
              row   <= '0;
              col   <= '0;
              busy  <= 1'b1;
              state <= RD;
            end
          end
        end
        RD: begin
          state <= WR;
        end
        WR: begin
          if (col == LAST_SHIFT_COL) begin
            col_req <= 1'b1;
            col_row <= row;
            state   <= NEWCOL;
          end else begin
            col   <= col + 6'd1;
            state <= RD;
          end
        end
        NEWCOL: begin
          if (col_valid) begin
            col_req <= 1'b0;
            if (row == LAST_ROW) begin
              state <= DONE;
            end else begin
              row   <= row + 5'd1;
              col   <= '0;
              state <= RD;
            end
          end
        end
        DONE: begin
          x_offset <= pend;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bg_scroll_controller.sv
// Scoreboard bench for bg_scroll_controller: directed frames queue expected events,
// a negedge monitor pops them as x_offset changes, shifts end, acks and overruns occur.
module tb_bg_scroll_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        scroll_en;
  logic [3:0]  scroll_speed;
  logic [3:0]  x_offset;
  logic        busy;
  logic        frame_overrun;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        col_req;
  logic [4:0]  col_row;
  logic        col_valid;
  logic [15:0] col_tile;
  logic        host_req;
  logic [10:0] host_addr;
  logic [15:0] host_data;
  logic        host_ack;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  exp_x_q[$];
  int          exp_len_q[$];
  logic [31:0] exp_ack_q[$];
  int          exp_ovr_q[$];

  always #5 clk = ~clk;

  bg_scroll_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .scroll_en(scroll_en),
    .scroll_speed(scroll_speed), .x_offset(x_offset), .busy(busy),
    .frame_overrun(frame_overrun), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .col_req(col_req),
    .col_row(col_row), .col_valid(col_valid), .col_tile(col_tile),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_ack(host_ack)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Tile RAM port A: synchronous write, read data one cycle after the address.
  logic [15:0] mem [0:1199];
  logic        preload_en = 1'b0;

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 1200; i++) mem[i] <= 16'(i);
    end else if (ram_we && ram_addr < 16'd1200) begin
      mem[ram_addr[10:0]] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 16'd1200) ? mem[ram_addr[10:0]] : 16'h0000;
  end

  // Game-logic column responder with a programmable per-row delay.
  int   col_delay = 0;
  int   col_wait  = 0;
  logic tile_mode = 1'b0;

  initial begin
    col_valid = 1'b0;
    col_tile  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (col_req) begin
        if (col_wait < col_delay) begin
          col_valid = 1'b0;
          col_wait++;
        end else begin
          col_valid = 1'b1;
          col_tile  = tile_mode ? (16'hC000 + 16'(col_row)) : 16'hABCD;
          col_wait  = 0;
        end
      end else begin
        col_valid = 1'b0;
        col_wait  = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an observable event.
  logic [3:0] prev_x    = 4'd0;
  logic       prev_busy = 1'b0;
  int         busy_cnt  = 0;
  int         we_cnt    = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_x    = x_offset;
      prev_busy = busy;
      busy_cnt  = 0;
    end else begin
      if (ram_we) we_cnt++;
      if (x_offset !== prev_x) begin
        if (exp_x_q.size() == 0) checkOutput("x_offset_unexpected_change", 32'(x_offset), 32'(prev_x));
        else checkOutput("x_offset", 32'(x_offset), 32'(exp_x_q.pop_front()));
        prev_x = x_offset;
      end
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (exp_len_q.size() == 0) checkOutput("shift_unexpected", 32'(busy_cnt), 32'd0);
        else checkOutput("shift_length", 32'(busy_cnt), 32'(exp_len_q.pop_front()));
        busy_cnt = 0;
      end
      prev_busy = busy;
      if (host_ack) begin
        if (exp_ack_q.size() == 0) checkOutput("host_ack_unexpected", 32'(host_ack), 32'd0);
        else begin
          checkOutput("host_write_addr_data", {ram_addr, ram_wdata}, exp_ack_q.pop_front());
          checkOutput("host_write_we", 32'(ram_we), 32'd1);
        end
      end
      if (frame_overrun) begin
        if (exp_ovr_q.size() == 0) checkOutput("frame_overrun_unexpected", 32'(frame_overrun), 32'd0);
        else checkOutput("frame_overrun", 32'(frame_overrun), 32'(exp_ovr_q.pop_front()));
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tick, input logic en, input logic [3:0] spd);
    frame_tick   = tick;
    scroll_en    = en;
    scroll_speed = spd;
    nextCycle();
    frame_tick = 1'b0;
  endtask

  task automatic waitShiftDone(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      nextCycle();
      n++;
    end
    checkOutput("shift_done_in_time", 32'(busy), 32'd0);
    repeat (3) nextCycle();
  endtask

  task automatic preloadRam();
    preload_en = 1'b1;
    nextCycle();
    preload_en = 1'b0;
  endtask

  task automatic checkRam(input string name, input logic row_tiles);
    int bad = 0;
    int first_bad = -1;
    logic [15:0] want;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 40; c++) begin
        if (c == 39) want = row_tiles ? (16'hC000 + 16'(r)) : 16'hABCD;
        else want = 16'(r * 40 + c + 1);
        if (mem[r * 40 + c] !== want) begin
          bad++;
          if (first_bad < 0) first_bad = r * 40 + c;
        end
      end
    end
    if (bad != 0) $display("[TB] first wrong word at address %0d", first_bad);
    checkOutput(name, 32'(bad), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_x_offset"}, 32'(x_offset), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_frame_overrun"}, 32'(frame_overrun), 32'd0);
    checkOutput({tag, "_col_req"}, 32'(col_req), 32'd0);
    checkOutput({tag, "_col_row"}, 32'(col_row), 32'd0);
    checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    checkOutput({tag, "_host_ack"}, 32'(host_ack), 32'd0);
  endtask

  initial begin
    int cycles;
    reset        = 1'b1;
    frame_tick   = 1'b0;
    scroll_en    = 1'b0;
    scroll_speed = 4'd0;
    host_req     = 1'b0;
    host_addr    = '0;
    host_data    = '0;
    repeat (3) nextCycle();
    checkResetOutputs("reset");
    reset = 1'b0;
    repeat (2) nextCycle();

    // Sub-tile advance: no RAM traffic, busy stays low, disabled tick ignored.
    we_cnt = 0;
    exp_x_q.push_back(4'd5);
    applyStimulus(1'b1, 1'b1, 4'd5);
    repeat (2) nextCycle();
    checkOutput("busy_subtile_1", 32'(busy), 32'd0);
    exp_x_q.push_back(4'd10);
    applyStimulus(1'b1, 1'b1, 4'd5);
    repeat (2) nextCycle();
    exp_x_q.push_back(4'd15);
    applyStimulus(1'b1, 1'b1, 4'd5);
    repeat (2) nextCycle();
    checkOutput("busy_subtile_3", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd5);
    repeat (2) nextCycle();
    checkOutput("x_offset_hold_when_disabled", 32'(x_offset), 32'd15);
    checkOutput("ram_we_during_subtile", 32'(we_cnt), 32'd0);

    // Host write in IDLE: acked in the same cycle, exactly once per request.
    exp_ack_q.push_back({16'd7, 16'h0123});
    host_addr = 11'd7;
    host_data = 16'h0123;
    host_req  = 1'b1;
    #1;
    checkOutput("host_ack_same_cycle", 32'(host_ack), 32'd1);
    nextCycle();
    checkOutput("host_ack_blocked_after_ack", 32'(host_ack), 32'd0);
    nextCycle();
    host_req = 1'b0;
    nextCycle();
    checkOutput("ram7_host_write", 32'(mem[7]), 32'h0123);

    // Boundary shift: 15 + 3 = 18 -> pend 2.
    preloadRam();
    tile_mode = 1'b0;
    col_delay = 0;
    exp_len_q.push_back(2371);
    exp_x_q.push_back(4'd2);
    applyStimulus(1'b1, 1'b1, 4'd3);
    checkOutput("busy_after_boundary_tick", 32'(busy), 32'd1);
    waitShiftDone(6000);
    checkRam("ram_after_shift", 1'b0);

    // Stalled column fetch; 2 + 14 lands exactly on the boundary -> pend 0.
    preloadRam();
    tile_mode = 1'b1;
    col_delay = 10;
    exp_len_q.push_back(2671);
    exp_x_q.push_back(4'd0);
    applyStimulus(1'b1, 1'b1, 4'd14);
    waitShiftDone(6000);
    checkRam("ram_after_stalled_shift", 1'b1);
    col_delay = 0;
    tile_mode = 1'b0;

    // Overrun: second tick 100 cycles into a 9 + 10 shift; only pend 3 lands.
    exp_x_q.push_back(4'd9);
    applyStimulus(1'b1, 1'b1, 4'd9);
    repeat (2) nextCycle();
    exp_len_q.push_back(2371);
    exp_x_q.push_back(4'd3);
    exp_ovr_q.push_back(1);
    applyStimulus(1'b1, 1'b1, 4'd10);
    repeat (99) nextCycle();
    applyStimulus(1'b1, 1'b1, 4'd10);
    waitShiftDone(6000);

    // Host request racing a tick: 3 + 13 shifts, ack the first IDLE cycle after DONE.
    exp_len_q.push_back(2371);
    exp_x_q.push_back(4'd0);
    exp_ack_q.push_back({16'd100, 16'hBEEF});
    host_addr    = 11'd100;
    host_data    = 16'hBEEF;
    host_req     = 1'b1;
    frame_tick   = 1'b1;
    scroll_en    = 1'b1;
    scroll_speed = 4'd13;
    #1;
    checkOutput("host_ack_loses_to_tick", 32'(host_ack), 32'd0);
    nextCycle();
    frame_tick = 1'b0;
    cycles = 1;
    while (!host_ack && cycles < 6000) begin
      nextCycle();
      cycles++;
    end
    checkOutput("host_ack_latency", 32'(cycles), 32'd2372);
    nextCycle();
    host_req = 1'b0;
    repeat (2) nextCycle();
    checkOutput("ram100_host_write", 32'(mem[100]), 32'hBEEF);

    // Async reset in the middle of row 12 of a shift.
    exp_x_q.push_back(4'd8);
    applyStimulus(1'b1, 1'b1, 4'd8);
    repeat (2) nextCycle();
    applyStimulus(1'b1, 1'b1, 4'd10);
    cycles = 0;
    while (col_row != 5'd12 && cycles < 3000) begin
      nextCycle();
      cycles++;
    end
    checkOutput("reached_row_12", 32'(col_row), 32'd12);
    checkOutput("busy_mid_shift", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkResetOutputs("midshift_reset");
    nextCycle();
    reset = 1'b0;
    repeat (2) nextCycle();
    exp_x_q.push_back(4'd4);
    applyStimulus(1'b1, 1'b1, 4'd4);
    repeat (3) nextCycle();
    checkOutput("busy_after_reset_tick", 32'(busy), 32'd0);

    repeat (3) nextCycle();
    checkOutput("scoreboard_leftover",
                32'(exp_x_q.size() + exp_len_q.size() + exp_ack_q.size() + exp_ovr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
